// File: rtl/inst_fetch_queue_pkg.sv
// Shared CPU front-end types: exception codes, fetch queue entries and decoded
// instruction records exchanged between fetch, the fetch queue and decode.
package inst_fetch_queue_pkg;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_SYS  = 5'd8,
    EXC_BP   = 5'd9,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    exc_code_e   ex;
    logic        ex_valid;
  } fetch_entry_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    exc_code_e   ex;
    logic        ex_valid;
  } decoded_inst_t;

endpackage

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue between fetch and decode: circular buffer with full
// flush and branch-redirect trim that preserves exactly one delay-slot entry.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     in_valid,
  input  fetch_entry_t             in_entry,
  output logic                     in_ready,
  output logic                     out_valid,
  output fetch_entry_t             out_entry,
  input  logic                     out_ready,
  input  logic                     flush,
  input  logic                     flush_ds,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count_q;
  logic          ds_pending;
  logic          ds_hold;
  fetch_entry_t  mem [DEPTH];

  logic          trim;
  logic          push;
  logic          pop;
  logic [AW-1:0] trim_rd;
  logic          trim_keep;

  // NOTE: flow control looks only at registered state, so out_ready never
  // reaches in_ready combinationally; a full queue stays closed for a cycle.
  assign in_ready  = (count_q != CW'(DEPTH)) && !ds_hold;
  assign out_valid = (count_q != '0);
  assign out_entry = mem[rd_ptr];
  assign count     = count_q;

  // Redirect with a non-empty queue trims to one entry and drops any arrival.
  assign trim      = flush_ds && out_valid && !flush;
  assign push      = in_valid && in_ready && !flush && !trim;
  assign pop       = out_valid && out_ready && !flush && !trim;
  assign trim_rd   = rd_ptr + AW'(out_ready);
  assign trim_keep = !(out_ready && (count_q == CW'(1)));

  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count_q    <= '0;
      ds_pending <= 1'b0;
      ds_hold    <= 1'b0;
    end else if (trim) begin
      rd_ptr     <= trim_rd;
      wr_ptr     <= trim_rd + AW'(trim_keep);
      count_q    <= CW'(trim_keep);
      ds_pending <= 1'b0;
      ds_hold    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      // Empty-queue redirect: the next accepted entry is the delay slot, and
      // admission closes for one cycle after it lands.
      if (flush_ds) begin
        ds_pending <= !push;
        ds_hold    <= push;
      end else if (ds_pending && push) begin
        ds_pending <= 1'b0;
        ds_hold    <= 1'b1;
      end else begin
        ds_hold    <= 1'b0;
      end
    end
  end

  // NOTE: the entry array has no reset; out_entry is ignored while out_valid=0,
  // so clearing it would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (push && resetn) mem[wr_ptr] <= in_entry;
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: a queue-level reference model is
// compared every cycle, plus hand-computed expectations for key scenarios.
module tb_inst_fetch_queue;
  import inst_fetch_queue_pkg::*;

  localparam int DEPTH = 8;

  logic               clk = 1'b0;
  logic               resetn;
  logic               in_valid;
  fetch_entry_t       in_entry;
  logic               in_ready;
  logic               out_valid;
  fetch_entry_t       out_entry;
  logic               out_ready;
  logic               flush;
  logic               flush_ds;
  logic [3:0]         count;

  int errors = 0;
  int checks = 0;
  logic cmp_en = 1'b0;

  fetch_entry_t m_q[$];
  logic m_pend = 1'b0;
  logic m_hold = 1'b0;

  always #5 clk = ~clk;

  inst_fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_entry  (in_entry),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_entry (out_entry),
    .out_ready (out_ready),
    .flush     (flush),
    .flush_ds  (flush_ds),
    .count     (count)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic fetch_entry_t mk(input logic [31:0] pc);
    fetch_entry_t e;
    e.pc       = pc;
    e.inst     = pc ^ 32'h5A5A_0F0F;
    e.ex       = EXC_INT;
    e.ex_valid = 1'b0;
    return e;
  endfunction

  function automatic logic m_ready();
    return (m_q.size() != DEPTH) && !m_hold;
  endfunction

  // Reference model: a plain queue updated from the rules at each edge.
  always @(posedge clk) begin
    logic acc;
    fetch_entry_t keep;
    if (!resetn || flush) begin
      m_q.delete();
      m_pend = 1'b0;
      m_hold = 1'b0;
    end else if (flush_ds && m_q.size() > 0) begin
      if (out_ready) void'(m_q.pop_front());
      if (m_q.size() > 0) begin
        keep = m_q[0];
        m_q.delete();
        m_q.push_back(keep);
      end
      m_pend = 1'b0;
      m_hold = 1'b0;
    end else begin
      acc = in_valid && m_ready();
      if (out_ready && m_q.size() > 0) void'(m_q.pop_front());
      if (acc) m_q.push_back(in_entry);
      if (flush_ds) begin
        m_pend = !acc;
        m_hold = acc;
      end else if (m_pend && acc) begin
        m_pend = 1'b0;
        m_hold = 1'b1;
      end else begin
        m_hold = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_count", 128'(count), 128'(m_q.size()));
      check("cyc_in_ready", 128'(in_ready), 128'(m_ready()));
      check("cyc_out_valid", 128'(out_valid), 128'(m_q.size() != 0));
      if (m_q.size() != 0) check("cyc_out_entry", 128'(out_entry), 128'(m_q[0]));
    end
  end

  task automatic step(input logic iv, input fetch_entry_t e, input logic ordy,
                      input logic fl, input logic fds);
    in_valid  = iv;
    in_entry  = e;
    out_ready = ordy;
    flush     = fl;
    flush_ds  = fds;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    flush_ds  = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push(input logic [31:0] pc);
    step(1'b1, mk(pc), 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 1; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    fetch_entry_t exe;
    resetn = 1'b1;
    in_valid = 1'b0; in_entry = '0; out_ready = 1'b0; flush = 1'b0; flush_ds = 1'b0;
    @(negedge clk);
    do_reset();
    cmp_en = 1'b1;
    check("rst_count", 128'(count), 128'(0));
    check("rst_in_ready", 128'(in_ready), 128'(1));
    check("rst_out_valid", 128'(out_valid), 128'(0));

    // Fill to full, then a dequeue while full must not admit the offered entry.
    for (int i = 0; i < 8; i++) push(32'hBFC0_0000 + 32'(4 * i));
    check("fill_count", 128'(count), 128'(8));
    check("fill_in_ready", 128'(in_ready), 128'(0));
    check("fill_head_pc", 128'(out_entry.pc), 128'(32'hBFC0_0000));
    step(1'b1, mk(32'hDEAD_0000), 1'b1, 1'b0, 1'b0);
    check("full_deq_count", 128'(count), 128'(7));
    check("full_deq_head", 128'(out_entry.pc), 128'(32'hBFC0_0004));
    drain();

    // Streaming through wraps the pointers several times.
    for (int k = 0; k < 20; k++) begin
      step(1'b1, mk(32'h0000_1000 + 32'(4 * k)), 1'b1, 1'b0, 1'b0);
      check("stream_count", 128'(count), 128'(1));
      check("stream_pc", 128'(out_entry.pc), 128'(32'h0000_1000 + 32'(4 * k)));
    end
    drain();

    // Flush beats simultaneous enqueue and dequeue.
    for (int i = 0; i < 5; i++) push(32'h0000_2000 + 32'(4 * i));
    check("pre_flush_count", 128'(count), 128'(5));
    step(1'b1, mk(32'h0000_3000), 1'b1, 1'b1, 1'b0);
    check("flush_count", 128'(count), 128'(0));
    check("flush_out_valid", 128'(out_valid), 128'(0));
    idle();
    check("flush_lost", 128'(count), 128'(0));

    // Delay-slot keep without consume.
    push(32'h100); push(32'h104); push(32'h108);
    step(1'b1, mk(32'h10C), 1'b0, 1'b0, 1'b1);
    check("ds_keep_count", 128'(count), 128'(1));
    check("ds_keep_pc", 128'(out_entry.pc), 128'(32'h100));
    drain();

    // Delay-slot keep with head consumed.
    push(32'h100); push(32'h104); push(32'h108);
    step(1'b0, '0, 1'b1, 1'b0, 1'b1);
    check("ds_cons_count", 128'(count), 128'(1));
    check("ds_cons_pc", 128'(out_entry.pc), 128'(32'h104));
    drain();

    // Redirect on an empty queue: only the first following entry is admitted.
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    push(32'h200);
    check("ds_empty_ready", 128'(in_ready), 128'(0));
    push(32'h204);
    idle();
    check("ds_empty_count", 128'(count), 128'(1));
    check("ds_empty_pc", 128'(out_entry.pc), 128'(32'h200));
    check("ds_empty_reopen", 128'(in_ready), 128'(1));
    drain();

    // Redirect and delay slot in the same cycle on an empty queue.
    step(1'b1, mk(32'h300), 1'b0, 1'b0, 1'b1);
    check("ds_same_count", 128'(count), 128'(1));
    check("ds_same_pc", 128'(out_entry.pc), 128'(32'h300));
    idle();
    drain();

    // Exception-tagged entries pass through untouched.
    exe.pc = 32'h8000_0180; exe.inst = 32'h0000_000C; exe.ex = EXC_RI; exe.ex_valid = 1'b1;
    step(1'b1, exe, 1'b0, 1'b0, 1'b0);
    check("ex_entry", 128'(out_entry), 128'({32'h8000_0180, 32'h0000_000C, 5'd10, 1'b1}));
    drain();

    // Reset mid-operation discards everything.
    for (int i = 0; i < 6; i++) push(32'h0000_4000 + 32'(4 * i));
    check("pre_rst_count", 128'(count), 128'(6));
    do_reset();
    check("mid_rst_count", 128'(count), 128'(0));
    check("mid_rst_in_ready", 128'(in_ready), 128'(1));
    check("mid_rst_out_valid", 128'(out_valid), 128'(0));
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inst_fetch_queue.md
INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, meaning queue entries (power of two, at least 2).
REQ-002 The block SHALL have port clk, input, 1, the single clock.
REQ-003 The block SHALL have port resetn, input, 1, reset; one clock, synchronous, active-low.
REQ-004 The block SHALL have port in_valid, input, 1, fetch presents an entry.
REQ-005 The block SHALL have port in_entry, input, fetch_entry_t, {pc[31:0], inst[31:0], ex[4:0] exception code, ex_valid}.
REQ-006 The block SHALL have port in_ready, output, 1, queue can accept.
REQ-007 The block SHALL have port out_valid, output, 1, head entry valid to decode.
REQ-008 The block SHALL have port out_entry, output, fetch_entry_t, head entry; out_entry.inst feeds the instruction decoder.
REQ-009 The block SHALL have port out_ready, input, 1, decode consumes head.
REQ-010 The block SHALL have port flush, input, 1, discard all entries (exception/eret).
REQ-011 The block SHALL have port flush_ds, input, 1, branch redirect; keep exactly one delay-slot entry.
REQ-012 The block SHALL have port count, output, $clog2(DEPTH)+1, current occupancy.

Function
REQ-013 Enqueue SHALL occur on a rising edge with in_valid & in_ready; dequeue SHALL occur with out_valid & out_ready.
REQ-014 in_ready SHALL equal (count != DEPTH), registered-state only, with no combinational path from out_ready.
REQ-015 out_valid SHALL equal (count != 0); out_entry SHALL be the oldest entry, driven from storage with no bypass of in_entry.
REQ-016 Latency: an entry enqueued at edge N SHALL be visible on out_valid/out_entry after edge N, i.e. during cycle N+1.
REQ-017 Simultaneous enqueue and dequeue SHALL leave count unchanged and preserve FIFO order.
REQ-018 When full, a dequeue SHALL NOT enable enqueue in the same cycle (in_ready stays 0).
REQ-019 Read and write pointers SHALL be $clog2(DEPTH) bits and wrap modulo DEPTH with no bubble.
REQ-020 flush SHALL take priority over everything: after the edge, count=0 and pointers are equal; any same-cycle enqueue or dequeue SHALL be ignored.
REQ-021 flush_ds with flush=0 and count>=1 SHALL keep only the head entry. If out_ready is also 1, the head SHALL be treated as consumed, and the entry after it (if present) SHALL be kept instead; if no entry follows, the queue SHALL be emptied.
REQ-022 flush_ds with count=0 SHALL arm a ds_pending flag. The next accepted entry SHALL be stored and ds_pending cleared. If that entry arrives in the same cycle as flush_ds, it SHALL be stored directly with count=1.
REQ-023 While ds_pending=1, accepted entries after the first SHALL NOT be admitted: in_ready=0 once the delay slot is stored, until the next edge clears the state.
REQ-024 flush SHALL also clear ds_pending.
REQ-025 Entries with ex_valid=1 SHALL pass through unchanged; the queue SHALL never alter pc, inst or ex.

Reset
REQ-026 While resetn=0 at an edge, count, pointers and ds_pending SHALL be 0; out_valid=0, in_ready=1.
REQ-027 Storage contents SHALL NOT require reset; out_entry is don't-care while out_valid=0.
REQ-028 Reset mid-operation SHALL discard all entries identically to flush.

Structure
REQ-029 fetch_entry_t and the exception code enum SHALL be defined in the shared cpu package header beside decoded_inst_t.
REQ-030 Storage SHALL be an inline register array of DEPTH fetch_entry_t; no sub-module is required.
REQ-031 Pointer and count logic SHALL be a single always_ff; flow-control outputs SHALL be derived combinationally from registered state only.

Verification
REQ-032 Fill: out_ready=0, enqueue pc 0xBFC00000..+0x1C (8 entries) -> count=8, in_ready=0, head pc=0xBFC00000.
REQ-033 Stream: in_valid=1 and out_ready=1 continuously with 20 sequential pcs -> output pcs in order, count constant at 1 after the first cycle, with a wrap past index 7.
REQ-034 Flush: count=5 with simultaneous flush, in_valid and out_ready -> next cycle count=0, out_valid=0, the input entry is lost.
REQ-035 Delay-slot keep: queue holds pc 0x100,0x104,0x108; assert flush_ds, out_ready=0 -> count=1, head pc=0x100.
REQ-036 Delay slot with consume: the same queue with flush_ds and out_ready=1 -> count=1, head pc=0x104. With empty queue, flush_ds then enqueue 0x200, 0x204 -> only 0x200 stored.
REQ-037 Reset: resetn=0 for one edge with count=6 -> count=0, in_ready=1, out_valid=0.
